cordic_hyp_seq: RTL

- Sequencer/controller for the `cordic_hyp` NCO core.
- Loads the core's 64x48 coefficient LUT from an external synchronous ROM, then applies frequency/phase configuration and pulses the core reset.
- Runs the core, captures valid output samples and stops after a programmed sample count.
- Sits between system control logic and one `cordic_hyp` instance, replacing hand-driven load/reset sequencing.

---
 rtl/cordic_hyp_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_hyp_seq.sv
// rtl/cordic_hyp_seq.sv - load/reset/run sequencer for one cordic_hyp NCO core
module cordic_hyp_seq #(
  parameter int NUM_SAMPLES = 4096,
  parameter int RST_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        reload,
  input  logic        stop,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_fcw,
  input  logic [15:0] cfg_offset,
  output logic        rom_en,
  output logic [5:0]  rom_addr,
  input  logic [47:0] rom_data,
  output logic        core_reset,
  output logic        core_cen,
  output logic        core_wen,
  output logic [5:0]  core_index,
  output logic [47:0] core_d,
  output logic [15:0] core_fcw,
  output logic [15:0] core_offset,
  input  logic [15:0] core_amp,
  input  logic        core_wen_out,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic        busy,
  output logic        done,
  output logic        lut_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, RSTP, RUN} state_e;

  localparam logic [6:0]  LOAD_LAST = 7'd64;
  localparam logic [6:0]  RST_LAST  = 7'(RST_CYCLES - 1);
  localparam logic [15:0] NS_LAST   = 16'(NUM_SAMPLES);
  localparam bit          FREE_RUN  = (NUM_SAMPLES == 0);

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] smp_cnt_q, smp_cnt_d;
  logic        lut_loaded_q, lut_loaded_d;
  logic        rom_en_q, rom_en_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic        core_reset_q, core_reset_d;
  logic        core_cen_q, core_cen_d;
  logic        core_wen_q, core_wen_d;
  logic [5:0]  core_index_q, core_index_d;
  logic [15:0] core_fcw_q, core_fcw_d;
  logic [15:0] core_offset_q, core_offset_d;
  logic        sample_valid_q, sample_valid_d;
  logic [15:0] sample_data_q, sample_data_d;
  logic        done_q, done_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    smp_cnt_d      = smp_cnt_q;
    lut_loaded_d   = lut_loaded_q;
    rom_en_d       = rom_en_q;
    rom_addr_d     = rom_addr_q;
    core_reset_d   = core_reset_q;
    core_cen_d     = core_cen_q;
    core_wen_d     = core_wen_q;
    core_index_d   = core_index_q;
    core_fcw_d     = core_fcw_q;
    core_offset_d  = core_offset_q;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    done_d         = 1'b0;

    if (cfg_valid && cfg_ready) begin
      core_fcw_d    = cfg_fcw;
      core_offset_d = cfg_offset;
    end

    if (stop) begin
      state_d      = IDLE;
      core_reset_d = 1'b1;
      core_cen_d   = 1'b1;
      core_wen_d   = 1'b1;
      rom_en_d     = 1'b0;
      if (state_q == LOAD) lut_loaded_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          core_reset_d = 1'b1;
          core_cen_d   = 1'b1;
          if (start) begin
            core_cen_d = 1'b0;
            cnt_d      = '0;
            if (reload || !lut_loaded_q) begin
              state_d      = LOAD;
              lut_loaded_d = 1'b0;
              rom_en_d     = 1'b1;
              rom_addr_d   = '0;
            end else begin
              state_d = RSTP;
            end
          end
        end
        LOAD: begin
          // ROM read for entry k+1 overlaps the core write of entry k
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LOAD_LAST) begin
            core_wen_d   = 1'b1;
            lut_loaded_d = 1'b1;
            state_d      = RSTP;
            cnt_d        = '0;
          end else begin
            core_wen_d   = 1'b0;
            core_index_d = cnt_q[5:0];
            rom_en_d     = (cnt_q < 7'd63);
            rom_addr_d   = cnt_q[5:0] + 6'd1;
          end
        end
        RSTP: begin
          smp_cnt_d = '0;
          cnt_d     = cnt_q + 7'd1;
          if (cnt_q == RST_LAST) begin
            state_d      = RUN;
            core_reset_d = 1'b0;
          end
        end
        RUN: begin
          if (core_wen_out) begin
            sample_valid_d = 1'b1;
            sample_data_d  = core_amp;
            smp_cnt_d      = smp_cnt_q + 16'd1;
            if (!FREE_RUN && (smp_cnt_q + 16'd1 == NS_LAST)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      smp_cnt_q      <= '0;
      lut_loaded_q   <= 1'b0;
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      core_reset_q   <= 1'b1;
      core_cen_q     <= 1'b1;
      core_wen_q     <= 1'b1;
      core_index_q   <= '0;
      core_fcw_q     <= '0;
      core_offset_q  <= '0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      smp_cnt_q      <= smp_cnt_d;
      lut_loaded_q   <= lut_loaded_d;
      rom_en_q       <= rom_en_d;
      rom_addr_q     <= rom_addr_d;
      core_reset_q   <= core_reset_d;
      core_cen_q     <= core_cen_d;
      core_wen_q     <= core_wen_d;
      core_index_q   <= core_index_d;
      core_fcw_q     <= core_fcw_d;
      core_offset_q  <= core_offset_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      done_q         <= done_d;
    end
  end

  // ROM data arrives the cycle after the read, so it passes straight through while writing
  assign core_d       = core_wen_q ? 48'd0 : rom_data;
  assign cfg_ready    = (state_q == IDLE) || (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign core_reset   = core_reset_q;
  assign core_cen     = core_cen_q;
  assign core_wen     = core_wen_q;
  assign core_index   = core_index_q;
  assign core_fcw     = core_fcw_q;
  assign core_offset  = core_offset_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign done         = done_q;
  assign lut_loaded   = lut_loaded_q;

endmodule
